if_id_fetch_stage: RTL and testbench

//  Fetch stage plus IF/ID pipeline register for the 16-bit pipelined LC-3b core.
//  - Owns the PC and drives the i-cache read handshake.
//  - Captures each returned instruction into IF/ID, with a 1-entry skid buffer for

---
 rtl/if_id_fetch_stage_if.sv | 24 ++
 rtl/if_id_fetch_stage.sv | 114 +++++++++++
 tb/tb_if_id_fetch_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_fetch_stage_if.sv
// I-cache read channel: fetch stage (master) issues address and read, cache (slave) returns rdata with a 1-cycle resp pulse.
// No backpressure: the master holds read/address stable until resp arrives.
interface if_id_fetch_stage_if #(
    parameter int ADDR_W = 16
);
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic [ADDR_W-1:0] i_mem_rdata;
    logic              i_mem_resp;

    modport master (
        output i_mem_read,
        output i_mem_address,
        input  i_mem_rdata,
        input  i_mem_resp
    );

    modport slave (
        input  i_mem_read,
        input  i_mem_address,
        output i_mem_rdata,
        output i_mem_resp
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// LC-3b fetch stage + IF/ID register: 1 cycle resp->if_id_valid when unstalled.
// Stall freezes IF/ID; a response caught during a stall parks in a 1-entry skid.
module if_id_fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dcache_stall,
    input  logic              ldi_stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    if_id_fetch_stage_if.master imem,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_ir
);
    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        HOLD     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] skid_pc_q;
    logic [ADDR_W-1:0] skid_ir_q;
    logic              valid_q;
    logic [ADDR_W-1:0] if_id_pc_q;
    logic [ADDR_W-1:0] if_id_ir_q;

    logic              stall;
    logic              br_eff;
    logic [ADDR_W-1:0] pc_inc;

    assign stall  = dcache_stall | ldi_stall;
    assign br_eff = br_taken & ~stall;
    assign pc_inc = pc_q + ADDR_W'(2);

    // pc_q is only retargeted once a request completes, so it is also the
    // address of the outstanding request while in REDIRECT.
    assign imem.i_mem_read    = rst_n & (state_q != HOLD);
    assign imem.i_mem_address = pc_q;

    assign if_id_valid = valid_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_ir    = if_id_ir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            tgt_q      <= '0;
            skid_pc_q  <= '0;
            skid_ir_q  <= '0;
            valid_q    <= 1'b0;
            if_id_pc_q <= '0;
            if_id_ir_q <= '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem.i_mem_resp) begin
                        if (br_eff) begin
                            pc_q    <= br_target;
                            valid_q <= 1'b0;
                        end else if (!stall) begin
                            if_id_pc_q <= pc_q;
                            if_id_ir_q <= imem.i_mem_rdata;
                            valid_q    <= 1'b1;
                            pc_q       <= pc_inc;
                        end else begin
                            skid_pc_q <= pc_q;
                            skid_ir_q <= imem.i_mem_rdata;
                            state_q   <= HOLD;
                        end
                    end else if (br_eff) begin
                        tgt_q   <= br_target;
                        valid_q <= 1'b0;
                        state_q <= REDIRECT;
                    end else if (!stall) begin
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (br_eff) begin
                        pc_q    <= br_target;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end else if (!stall) begin
                        if_id_pc_q <= skid_pc_q;
                        if_id_ir_q <= skid_ir_q;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_inc;
                        state_q    <= FETCH;
                    end
                end
                REDIRECT: begin
                    valid_q <= 1'b0;
                    if (imem.i_mem_resp) begin
                        pc_q    <= br_eff ? br_target : tgt_q;
                        state_q <= FETCH;
                    end else if (br_eff) begin
                        tgt_q <= br_target;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage; inputs change and outputs are sampled 1ns after each rising edge.
module tb_if_id_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dcache_stall;
    logic        ldi_stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic        if_id_valid;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_ir;

    int vectors = 0;
    int miscompares = 0;

    if_id_fetch_stage_if #(.ADDR_W(16)) imem ();

    if_id_fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dcache_stall (dcache_stall),
        .ldi_stall    (ldi_stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .imem         (imem.master),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_ir     (if_id_ir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic resp, input logic [15:0] rdata, input logic br,
                         input logic [15:0] tgt, input logic dst, input logic lst);
        imem.i_mem_resp  = resp;
        imem.i_mem_rdata = rdata;
        br_taken         = br;
        br_target        = tgt;
        dcache_stall     = dst;
        ldi_stall        = lst;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [15:0] pc,
                            input logic [15:0] ir);
        chk({tag, "_valid"}, {15'd0, if_id_valid}, {15'd0, v});
        chk({tag, "_pc"}, if_id_pc, pc);
        chk({tag, "_ir"}, if_id_ir, ir);
    endtask

    task automatic chk_mem(input string tag, input logic rd, input logic [15:0] addr);
        chk({tag, "_read"}, {15'd0, imem.i_mem_read}, {15'd0, rd});
        chk({tag, "_addr"}, imem.i_mem_address, addr);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        chk_mem("reset", 1'b0, 16'h0000);
        chk_ifid("reset", 1'b0, 16'h0000, 16'h0000);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk_mem("post_reset", 1'b1, 16'h0000);

        // 1: in-order stream, resp every 2nd cycle
        step();
        chk("t1_bubble_valid", {15'd0, if_id_valid}, 16'd0);
        chk_mem("t1_wait0", 1'b1, 16'h0000);
        drive(1'b1, 16'hA000, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t1_i0", 1'b1, 16'h0000, 16'hA000);
        chk_mem("t1_a1", 1'b1, 16'h0002);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk("t1_pulse_end", {15'd0, if_id_valid}, 16'd0);
        drive(1'b1, 16'hA001, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t1_i1", 1'b1, 16'h0002, 16'hA001);
        chk_mem("t1_a2", 1'b1, 16'h0004);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        drive(1'b1, 16'hA002, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t1_i2", 1'b1, 16'h0004, 16'hA002);
        chk_mem("t1_a3", 1'b1, 16'h0006);

        // resp + branch jumps to 0010
        drive(1'b1, 16'hBAD0, 1'b1, 16'h0010, 1'b0, 1'b0); step();
        chk_ifid("jmp10", 1'b0, 16'h0004, 16'hA002);
        chk_mem("jmp10", 1'b1, 16'h0010);

        // 2: response during a 3-cycle D-cache stall, stray branch ignored
        drive(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0); step();
        chk_mem("t2_hold1", 1'b0, 16'h0010);
        chk_ifid("t2_hold1", 1'b0, 16'h0004, 16'hA002);
        drive(1'b0, 16'h0000, 1'b1, 16'hBEEE, 1'b1, 1'b0); step();
        chk_mem("t2_hold2", 1'b0, 16'h0010);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0); step();
        chk_ifid("t2_hold3", 1'b0, 16'h0004, 16'hA002);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t2_release", 1'b1, 16'h0010, 16'h1234);
        chk_mem("t2_release", 1'b1, 16'h0012);

        drive(1'b1, 16'hBAD1, 1'b1, 16'h0020, 1'b0, 1'b0); step();
        chk_mem("jmp20", 1'b1, 16'h0020);

        // 3: redirect with fetch outstanding
        drive(1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b0); step();
        chk_mem("t3_redir1", 1'b1, 16'h0020);
        chk("t3_redir1_valid", {15'd0, if_id_valid}, 16'd0);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_mem("t3_redir2", 1'b1, 16'h0020);
        drive(1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t3_drop", 1'b0, 16'h0010, 16'h1234);
        chk_mem("t3_next", 1'b1, 16'h0040);

        // newest redirect target wins
        drive(1'b0, 16'h0000, 1'b1, 16'h0050, 1'b0, 1'b0); step();
        drive(1'b0, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b0); step();
        chk_mem("newest_wait", 1'b1, 16'h0040);
        drive(1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_mem("newest", 1'b1, 16'h0030);

        // 4: branch + resp same cycle, then the same under ldi_stall
        drive(1'b1, 16'h7777, 1'b1, 16'h0100, 1'b0, 1'b0); step();
        chk_ifid("t4_discard", 1'b0, 16'h0010, 16'h1234);
        chk_mem("t4_next", 1'b1, 16'h0100);
        drive(1'b1, 16'h8888, 1'b1, 16'h0200, 1'b0, 1'b1); step();
        chk_mem("t4_ldi_hold", 1'b0, 16'h0100);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t4_ldi_rel", 1'b1, 16'h0100, 16'h8888);
        chk_mem("t4_ldi_rel", 1'b1, 16'h0102);

        // 5: PC wrap
        drive(1'b1, 16'hBAD2, 1'b1, 16'hFFFE, 1'b0, 1'b0); step();
        chk_mem("t5_at_fffe", 1'b1, 16'hFFFE);
        drive(1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t5_wrap", 1'b1, 16'hFFFE, 16'h5555);
        chk_mem("t5_wrap", 1'b1, 16'h0000);

        // 6a: async reset in HOLD
        drive(1'b1, 16'h6666, 1'b0, 16'h0000, 1'b1, 1'b0); step();
        chk_mem("t6_in_hold", 1'b0, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_ifid("t6_hold_rst", 1'b0, 16'h0000, 16'h0000);
        chk_mem("t6_hold_rst", 1'b0, 16'h0000);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        chk_mem("t6_hold_rel", 1'b1, 16'h0000);
        step();
        chk("t6_no_skid_replay", {15'd0, if_id_valid}, 16'd0);

        // 6b: async reset in REDIRECT
        drive(1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t6_pre", 1'b1, 16'h0000, 16'h1111);
        drive(1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 1'b0); step();
        chk_mem("t6_in_redir", 1'b1, 16'h0002);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_ifid("t6_redir_rst", 1'b0, 16'h0000, 16'h0000);
        chk_mem("t6_redir_rst", 1'b0, 16'h0000);
        step();
        rst_n = 1'b1;
        #1;
        chk_mem("t6_redir_rel", 1'b1, 16'h0000);
        drive(1'b1, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0); step();
        chk_ifid("t6_first", 1'b1, 16'h0000, 16'hA5A5);
        chk_mem("t6_first", 1'b1, 16'h0002);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
